// File: rtl/register_file.sv
// Y86-64 architectural register file: combinational reads, rising-edge write-back.
// Define REGFILE_DUMP_EN to expose the reg_dump debug port (R[0] in the LSBs).
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB
`ifdef REGFILE_DUMP_EN
  ,
  output logic [959:0] reg_dump
`endif
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] NOREG = 4'hF;

  logic [63:0] regs_q [15];
  logic [3:0]  srcA, srcB, dstE, dstM;
  icode_t      op;

  assign op = icode_t'(icode);

  always_comb begin
    srcA = NOREG;
    srcB = NOREG;
    dstE = NOREG;
    dstM = NOREG;
    case (op)
      I_RRMOVQ: begin
        srcA = rA;
        if (cnd) dstE = rB;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP;
        dstE = RSP;
      end
      I_RET: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      I_POPQ: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  always_comb begin
    valA = '0;
    valB = '0;
    if (srcA != NOREG) valA = regs_q[srcA];
    if (srcB != NOREG) valB = regs_q[srcB];
  end

  // dstM is written after dstE so valM wins when both target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      if (dstE != NOREG) regs_q[dstE] <= valE;
      if (dstM != NOREG) regs_q[dstM] <= valM;
    end
  end

`ifdef REGFILE_DUMP_EN
  always_comb begin
    reg_dump = '0;
    for (int unsigned i = 0; i < 15; i++) reg_dump[64*i +: 64] = regs_q[i];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; registers are inspected through
// the read ports (and reg_dump when REGFILE_DUMP_EN is defined).
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM, valA, valB;
`ifdef REGFILE_DUMP_EN
  logic [959:0] reg_dump;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] m [15];
  logic [63:0] v;

  localparam logic [63:0] BASE = 64'h3424867AEC;

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .cnd   (cnd),
    .rA    (rA),
    .rB    (rB),
    .valE  (valE),
    .valM  (valM),
    .valA  (valA),
    .valB  (valB)
`ifdef REGFILE_DUMP_EN
    ,
    .reg_dump (reg_dump)
`endif
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read R[idx] through source A using OPq decode, then restore the inputs
  task automatic peek(input logic [3:0] idx, output logic [63:0] val);
    logic [3:0] s_icode, s_rA, s_rB;
    s_icode = icode; s_rA = rA; s_rB = rB;
    icode = 4'h6; rA = idx; rB = 4'h0;
    #1 val = valA;
    icode = s_icode; rA = s_rA; rB = s_rB;
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] r;
    for (int i = 0; i < 15; i++) begin
      peek(4'(i), r);
      check($sformatf("%s_R%0d", tag, i), r, m[i]);
`ifdef REGFILE_DUMP_EN
      check($sformatf("%s_dump%0d", tag, i), reg_dump[64*i +: 64], m[i]);
`endif
    end
  endtask

  initial begin
    icode = 4'h0; cnd = 1'b0; rA = 4'h0; rB = 4'h0; valE = '0; valM = '0;
    for (int i = 0; i < 15; i++) m[i] = '0;

    // Reset asserted mid-cycle, reads go to zero without a clock edge
    #30 rst_n = 1'b0;
    #1 icode = 4'h6; rA = 4'h1; rB = 4'h2;
    #1 check("rst_opq_valA", valA, 64'h0);
    check("rst_opq_valB", valB, 64'h0);
    icode = 4'hB;
    #1 check("rst_popq_valA", valA, 64'h0);
    check("rst_popq_valB", valB, 64'h0);
    icode = 4'h0;
    check_all("rst");
    @(negedge clk) rst_n = 1'b1;

    // popq rA=2: R4<=valE, R2<=valM; no bypass before the edge
    icode = 4'hB; rA = 4'h2; rB = 4'h7; cnd = 1'b0; valE = BASE; valM = 64'h6567;
    #1 check("popq_pre_valA", valA, 64'h0);
    @(posedge clk); #1;
    check("popq_post_valA", valA, BASE);
    check("popq_post_valB", valB, BASE);
    m[4] = BASE; m[2] = 64'h6567;
    check_all("popq1");

    for (int i = 1; i <= 3; i++) begin
      valE = BASE + 64'(i);
      #1 check($sformatf("popq_rep%0d_pre", i), valA, BASE + 64'(i - 1));
      @(posedge clk); #1;
      check($sformatf("popq_rep%0d_post", i), valA, BASE + 64'(i));
    end
    m[4] = 64'h3424867AEF;
    check_all("popq4");

    // cmov gated by cnd
    icode = 4'h2; rA = 4'h0; rB = 4'h3; valE = 64'h55; valM = 64'h0; cnd = 1'b0;
    @(posedge clk); #1;
    peek(4'h3, v); check("cmov_cnd0_R3", v, 64'h0);
    cnd = 1'b1;
    @(posedge clk); #1;
    peek(4'h3, v); check("cmov_cnd1_R3", v, 64'h55);
    m[3] = 64'h55;
    cnd = 1'b0;

    // popq %rsp: valM beats valE
    icode = 4'hB; rA = 4'h4; rB = 4'hF; valE = 64'h10; valM = 64'h99;
    @(posedge clk); #1;
    peek(4'h4, v); check("popq_rsp_R4", v, 64'h99);
    m[4] = 64'h99;

    // irmovq to F writes nothing
    icode = 4'h3; rA = 4'hF; rB = 4'hF; valE = 64'h1;
    #1 check("irmovq_F_valA", valA, 64'h0);
    check("irmovq_F_valB", valB, 64'h0);
    @(posedge clk); #1;
    check_all("irmovqF");

    // icode 0: no reads, no writes
    icode = 4'h0; rA = 4'h3; rB = 4'h4; valE = 64'hDEAD; valM = 64'hBEEF;
    #1 check("halt_valA", valA, 64'h0);
    check("halt_valB", valB, 64'h0);
    @(posedge clk); #1;
    check_all("halt");

    // irmovq, mrmovq, OPq, call
    icode = 4'h3; rA = 4'hF; rB = 4'h5; valE = 64'hAB;
    @(posedge clk); #1;
    m[5] = 64'hAB;
    icode = 4'h5; rA = 4'h6; rB = 4'h3; valE = 64'h0; valM = 64'h77;
    #1 check("mrmovq_valB", valB, 64'h55);
    @(posedge clk); #1;
    m[6] = 64'h77;
    icode = 4'h6; rA = 4'h3; rB = 4'h5; valE = 64'h100; valM = 64'h0;
    #1 check("opq_valA", valA, 64'h55);
    check("opq_valB", valB, 64'hAB);
    @(posedge clk); #1;
    m[5] = 64'h100;
    icode = 4'h8; rA = 4'hF; rB = 4'hF; valE = 64'h91;
    #1 check("call_valA", valA, 64'h0);
    check("call_valB", valB, 64'h99);
    @(posedge clk); #1;
    m[4] = 64'h91;
    icode = 4'h0;
    check_all("mixed");

    // Write edge during active reset is ignored
    icode = 4'h3; rB = 4'h5; valE = 64'hFF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    icode = 4'h0;
    for (int i = 0; i < 15; i++) m[i] = '0;
    check_all("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
